// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  localparam int DEFAULT_MAX_WAIT = 8;

endpackage

// File: rtl/arb_priority.sv
// rtl/arb_priority.sv - winner selection between fetch and data requesters
// MEM_ARB_ROUND_ROBIN_EN selects alternating priority instead of data-first with starvation override.
module arb_priority
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    arb_en,
  input  logic    if_req,
  input  logic    d_req,
  output logic    gnt_any,
  output req_id_t winner
);

  logic if_wins;

  assign gnt_any = arb_en && (if_req || d_req);
  assign winner  = if_wins ? REQ_IF : REQ_D;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_t last_q, last_d;

  // On contention the port that did not win last time goes first.
  always_comb begin
    if_wins = if_req && (!d_req || (last_q == REQ_D));
    last_d  = gnt_any ? winner : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_IF;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_q, wait_d;

  // Counts IDLE cycles a fetch is refused; at saturation fetch overrides data.
  always_comb begin
    if_wins = if_req && (!d_req || (wait_q == WAIT_MAX));
    wait_d  = wait_q;
    if (!if_req || (gnt_any && if_wins)) begin
      wait_d = '0;
    end else if (arb_en && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-cycle grant/response arbiter between fetch and data ports
// MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration inside arb_priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic              if_we,
  input  logic [DATA_W-1:0] if_addr,
  input  logic [DATA_W-1:0] if_wdata,
  input  logic [2:0]        if_funct3,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_funct3,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              memory_write_en,
  output logic [DATA_W-1:0] memory_write_address,
  output logic [DATA_W-1:0] memory_write,
  output logic [DATA_W-1:0] memory_read_address,
  output logic [2:0]        memory_funct3,
  input  logic [DATA_W-1:0] memory_read_value,
  output logic              busy
);

  arb_state_t state_q, state_d;
  req_id_t    gnt_id_q, gnt_id_d;
  logic       gnt_we_q, gnt_we_d;
  logic       arb_en, gnt_any, sel_d, resp_valid;
  req_id_t    winner;

  assign arb_en = (state_q == IDLE) && !rst;

  arb_priority #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb_priority (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (arb_en),
    .if_req  (if_req),
    .d_req   (d_req),
    .gnt_any (gnt_any),
    .winner  (winner)
  );

  assign sel_d  = (winner == REQ_D);
  assign if_gnt = gnt_any && !sel_d;
  assign d_gnt  = gnt_any && sel_d;

  always_comb begin
    memory_write_address = sel_d ? d_addr : if_addr;
    memory_read_address  = memory_write_address;
    memory_write         = sel_d ? d_wdata : if_wdata;
    memory_funct3        = sel_d ? d_funct3 : if_funct3;
    memory_write_en      = gnt_any && (sel_d ? d_we : if_we);
  end

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    gnt_we_d = gnt_we_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d  = RESP;
          gnt_id_d = winner;
          gnt_we_d = sel_d ? d_we : if_we;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_id_q <= REQ_IF;
      gnt_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      gnt_we_q <= gnt_we_d;
    end
  end

  // A reset landing in RESP drops the response outright.
  assign resp_valid = (state_q == RESP) && !rst;

  always_comb begin
    if_rvalid = resp_valid && (gnt_id_q == REQ_IF);
    d_rvalid  = resp_valid && (gnt_id_q == REQ_D);
    if_rdata  = (if_rvalid && !gnt_we_q) ? memory_read_value : '0;
    d_rdata   = (d_rvalid && !gnt_we_q) ? memory_read_value : '0;
  end

  assign busy = (state_q == RESP);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_we, d_req, d_we;
  logic [31:0] if_addr, if_wdata, d_addr, d_wdata;
  logic [2:0]  if_funct3, d_funct3;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        memory_write_en;
  logic [31:0] memory_write_address, memory_write, memory_read_address;
  logic [2:0]  memory_funct3;
  logic [31:0] memory_read_value;
  logic        busy;

  mem_arbiter #(.DATA_W(32), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_we(if_we), .if_addr(if_addr), .if_wdata(if_wdata),
    .if_funct3(if_funct3), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_funct3(d_funct3), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .memory_write_en(memory_write_en), .memory_write_address(memory_write_address),
    .memory_write(memory_write), .memory_read_address(memory_read_address),
    .memory_funct3(memory_funct3), .memory_read_value(memory_read_value),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } gnt_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } resp_t;

  gnt_t  exp_gnt[$];
  resp_t exp_resp[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int gnt_count = 0;
  int gnt_cyc[2];

  // Read data: one fixed location, otherwise an address-derived pattern.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    memory_read_value <= (memory_read_address == 32'h10) ? 32'hDEADBEEF
                                                         : (memory_read_address ^ 32'h5A5A_0000);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin
    gnt_t  g;
    resp_t r;
    logic  p;
    if (if_gnt && d_gnt) flag("gnt_onehot");
    if (if_gnt || d_gnt) begin
      p = d_gnt;
      if (exp_gnt.size() == 0) begin
        flag("unexpected_gnt");
      end else begin
        g = exp_gnt.pop_front();
        check("gnt_port", {31'b0, p}, {31'b0, g.port});
        check("gnt_we", {31'b0, memory_write_en}, {31'b0, g.we});
        check("gnt_waddr", memory_write_address, g.addr);
        check("gnt_raddr", memory_read_address, g.addr);
        check("gnt_f3", {29'b0, memory_funct3}, {29'b0, g.f3});
        if (g.we) check("gnt_wdata", memory_write, g.wdata);
      end
      gnt_cyc[p] = cyc;
      gnt_count++;
    end else if (memory_write_en) begin
      flag("stray_write_en");
    end
    if (if_rvalid && d_rvalid) flag("rvalid_onehot");
    if (if_rvalid || d_rvalid) begin
      p = d_rvalid;
      if (exp_resp.size() == 0) begin
        flag("unexpected_rvalid");
      end else begin
        r = exp_resp.pop_front();
        check("resp_port", {31'b0, p}, {31'b0, r.port});
        check("resp_data", p ? d_rdata : if_rdata, r.data);
        check("resp_other_rdata", p ? if_rdata : d_rdata, 32'h0);
        check("resp_latency", cyc - gnt_cyc[p], 32'd1);
      end
    end
  end

  task automatic push_g(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3);
    gnt_t g;
    g.port = port; g.we = we; g.addr = addr; g.wdata = wdata; g.f3 = f3;
    exp_gnt.push_back(g);
  endtask

  task automatic push_r(input logic port, input logic [31:0] data);
    resp_t r;
    r.port = port; r.data = data;
    exp_resp.push_back(r);
  endtask

  // Wait for the port's grant, then drop its request in the following RESP cycle.
  task automatic wait_drop(input logic port);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = port ? d_gnt : if_gnt;
    end
    if (!seen) flag(port ? "timeout_d_gnt" : "timeout_if_gnt");
    @(posedge clk); #1;
    if (port) d_req = 1'b0; else if_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int target;
    rst = 1'b1;
    if_req = 0; if_we = 0; if_addr = 0; if_wdata = 0; if_funct3 = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0;
    repeat (2) @(posedge clk);
    #1 d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44;
    @(negedge clk);
    check("rst_blocks_gnt", {31'b0, d_gnt}, 32'h0);
    check("rst_blocks_we", {31'b0, memory_write_en}, 32'h0);
    @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'h0);
    check("reset_gnt", {30'b0, if_gnt, d_gnt}, 32'h0);

    // Fetch read returning the fixed word.
    @(posedge clk); #1;
    if_req = 1'b1; if_we = 1'b0; if_addr = 32'h10; if_funct3 = 3'd2;
    push_g(1'b0, 1'b0, 32'h10, 32'h0, 3'd2);
    push_r(1'b0, 32'hDEADBEEF);
    wait_drop(1'b0);
    @(negedge clk);
    check("busy_in_resp", {31'b0, busy}, 32'h1);

    // Simultaneous requests: data write wins, fetch follows two cycles later.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55; d_funct3 = 3'd2;
    if_req = 1'b1; if_we = 1'b0; if_addr = 32'h14; if_funct3 = 3'd2;
    push_g(1'b1, 1'b1, 32'h200, 32'h55, 3'd2);
    push_r(1'b1, 32'h0);
    push_g(1'b0, 1'b0, 32'h14, 32'h0, 3'd2);
    push_r(1'b0, 32'h5A5A_0014);
    wait_drop(1'b1);
    d_we = 1'b0;
    wait_drop(1'b0);
    check("if_gnt_after_d", gnt_cyc[0] - gnt_cyc[1], 32'd2);

    // Fetch write of a halfword answers with zero data.
    @(posedge clk); #1;
    if_req = 1'b1; if_we = 1'b1; if_addr = 32'h24; if_wdata = 32'h1234; if_funct3 = 3'd1;
    push_g(1'b0, 1'b1, 32'h24, 32'h1234, 3'd1);
    push_r(1'b0, 32'h0);
    wait_drop(1'b0);
    if_we = 1'b0;

    // Reset in the RESP cycle of a data read abandons the response.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_funct3 = 3'd2;
    push_g(1'b1, 1'b0, 32'h80, 32'h0, 3'd2);
    wait_drop(1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("busy_after_rst", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    d_req = 1'b1; d_addr = 32'h84;
    push_g(1'b1, 1'b0, 32'h84, 32'h0, 3'd2);
    push_r(1'b1, 32'h5A5A_0084);
    wait_drop(1'b1);

    // Both ports requesting continuously from reset.
    pulse_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_funct3 = 3'd2;
    if_req = 1'b1; if_we = 1'b0; if_addr = 32'h40; if_funct3 = 3'd2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        push_g(1'b1, 1'b0, 32'h300, 32'h0, 3'd2); push_r(1'b1, 32'h5A5A_0300);
      end else begin
        push_g(1'b0, 1'b0, 32'h40, 32'h0, 3'd2); push_r(1'b0, 32'h5A5A_0040);
      end
    end
`else
    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin
        push_g(1'b0, 1'b0, 32'h40, 32'h0, 3'd2); push_r(1'b0, 32'h5A5A_0040);
      end else begin
        push_g(1'b1, 1'b0, 32'h300, 32'h0, 3'd2); push_r(1'b1, 32'h5A5A_0300);
      end
    end
`endif
    target = gnt_count + 10;
    for (int i = 0; i < 60 && gnt_count < target; i++) begin
      @(negedge clk); #1;
    end
    check("contention_grants", gnt_count, target);
    @(posedge clk); #1;
    d_req = 1'b0; if_req = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("exp_gnt_drained", exp_gnt.size(), 32'd0);
    check("exp_resp_drained", exp_resp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: data and address width.
REQ-002 Parameter MAX_WAIT, default 8: cycles a pending fetch may be refused before it is forced to win.
REQ-003 Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req, if_we  in  1 each  fetch request and write flag.
- if_addr, if_wdata  in  DATA_W each  fetch address and write data.
- if_funct3  in  3  fetch access size.
- if_gnt, if_rvalid  out  1 each  fetch grant and response valid.
- if_rdata  out  DATA_W  fetch read data.
- d_req, d_we, d_addr, d_wdata, d_funct3, d_gnt, d_rvalid, d_rdata: data port, identical roles and widths to the fetch port.
- memory_write_en  out  1  memory write strobe.
- memory_write_address, memory_write, memory_read_address  out  DATA_W each  memory addresses and write data.
- memory_funct3  out  3  memory access size.
- memory_read_value  in  DATA_W  memory read data, valid one cycle after the read address.
- busy  out  1  high when state is RESP.

Function
REQ-004 FSM has two states: IDLE (issue) and RESP (response); IDLE->RESP on any grant; RESP->IDLE always.
REQ-005 In IDLE, at most one gnt is asserted, combinationally, in the same cycle as the winning req; no gnt when no req.
REQ-006 On grant, the winner's addr, funct3 and wdata drive both memory address ports, memory_funct3 and memory_write combinationally; memory_write_en = winner's we.
REQ-007 In RESP, the granted port's rvalid = 1 for exactly one cycle; rdata = memory_read_value for reads and 0 for writes.
REQ-008 Every access is 2 cycles (grant, response); peak throughput is one access per 2 cycles; no grant is issued in RESP.
REQ-009 memory_write_en = 0 in every cycle without a write grant; memory outputs in those cycles are don't-care except memory_write_en.
REQ-010 Requester holds req and its payload stable until gnt; dropping req before gnt is legal and has no effect.
REQ-011 Default arbitration: data wins over fetch, unless the starvation counter equals MAX_WAIT, in which case fetch wins.
REQ-012 Starvation counter: +1 each IDLE cycle with if_req high and if_gnt low; saturates at MAX_WAIT; clears on if_gnt or when if_req is low.
REQ-013 rdata of the non-granted port = 0; rvalid of both ports = 0 in IDLE.

Reset
REQ-014 rst high: state = IDLE, starvation counter = 0, last-granted = fetch, all gnt/rvalid = 0, memory_write_en = 0, busy = 0, effective next cycle.
REQ-015 rst asserted in RESP abandons the access: no rvalid is produced, and any write already strobed is not undone.
REQ-016 Any rst held high suppresses gnt and memory_write_en combinationally.

Configuration
REQ-017 Macro MEM_ARB_ROUND_ROBIN_EN defined: when both ports request, the port not granted last wins, and the starvation counter is not compiled in.
REQ-018 MEM_ARB_ROUND_ROBIN_EN undefined: fixed data priority with the starvation override of REQ-011/012; last-granted is not compiled in.

Structure
REQ-019 Package mem_arb_pkg holds: enum arb_state_t {IDLE, RESP}; enum req_id_t {REQ_IF = 0, REQ_D = 1}; and the default MAX_WAIT constant.
REQ-020 One sub-module, arb_priority, contains the winner selection, the starvation counter and the last-granted register; the FSM and muxing live in mem_arbiter.

Verification
REQ-021 Fetch read only, if_addr = 0x10, memory returns 0xDEADBEEF -> if_gnt in cycle 0, if_rvalid with 0xDEADBEEF in cycle 1, d_rvalid stays 0.
REQ-022 Both ports request in the same cycle, d_we = 1, d_addr = 0x200, d_wdata = 0x55 -> d_gnt first with memory_write_en = 1 and memory_write = 0x55; if_gnt follows 2 cycles later.
REQ-023 Default build, d_req held high continuously with if_req high -> fetch is refused 8 IDLE cycles, then if_gnt on the next IDLE cycle, and the counter returns to 0.
REQ-024 MEM_ARB_ROUND_ROBIN_EN build, both ports requesting continuously -> grants alternate D, IF, D, IF from reset.
REQ-025 rst pulsed in the RESP cycle of a data read -> no d_rvalid, busy = 0 and state = IDLE the next cycle, and a new request is granted normally afterwards.
